// File: rtl/alu_control_if.sv
// alu_control_if: request/response, slice-control and slice-feedback bundle for alu_control
interface alu_control_if #(parameter int WIDTH = 16);
    logic             start;
    logic [3:0]       opcode;
    logic [3:0]       sh_amt;
    logic             busy;
    logic             done;
    logic             sub;
    logic             zero_a;
    logic             c_in;
    logic             fa_out;
    logic             op_and;
    logic             op_or;
    logic             op_xor;
    logic             op_not;
    logic             op_nand;
    logic             op_nor;
    logic             sh8;
    logic             sh4;
    logic             sh2;
    logic             sh1;
    logic             sh_b;
    logic             sh_l;
    logic             sh_r;
    logic             sh_out;
    logic [WIDTH-1:0] alu_out;
    logic             c_out;
    logic             n_z;
    logic [WIDTH-1:0] result;
    logic             flag_z;
    logic             flag_c;
    logic             flag_n;
    modport master (
        output start, opcode, sh_amt, alu_out, c_out, n_z,
        input  busy, done, sub, zero_a, c_in, fa_out, op_and, op_or, op_xor, op_not, op_nand, op_nor,
               sh8, sh4, sh2, sh1, sh_b, sh_l, sh_r, sh_out, result, flag_z, flag_c, flag_n
    );
    modport slave (
        input  start, opcode, sh_amt, alu_out, c_out, n_z,
        output busy, done, sub, zero_a, c_in, fa_out, op_and, op_or, op_xor, op_not, op_nand, op_nor,
               sh8, sh4, sh2, sh1, sh_b, sh_l, sh_r, sh_out, result, flag_z, flag_c, flag_n
    );
endinterface

// File: rtl/alu_control.sv
// alu_control: sequences one ALU operation across bit slices and captures result/flags.
// Optional macro ALU_CONTROL_CARRY_IN_EN makes ADC/SBC take CIn from FlagC.
module alu_control #(
    parameter int WIDTH  = 16,
    parameter int SETTLE = 1
) (
    input logic             clk,
    input logic             rst,
    alu_control_if.slave    bus
);
    typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_SETTLE, S_CAPTURE, S_DONE} state_t;
    state_t           state;
    logic [2:0]       cnt;
    logic [3:0]       op;
    logic             arith;
    logic             shift;
    logic             cin;
    logic [17:0]      ctl_d;
    logic [17:0]      ctl_q;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             flag_z;
    logic             flag_c;
    logic             flag_n;
    assign op = bus.opcode;
    // control vector order: sub, zero_a, c_in, fa_out, logic x6, shift amount x4, sh_b, sh_l, sh_r, sh_out
    always_comb begin
        arith = op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd14, 4'd15};
        shift = op inside {[4'd10:4'd13]};
`ifdef ALU_CONTROL_CARRY_IN_EN
        cin = op inside {4'd1, 4'd15} || (op inside {4'd2, 4'd3} && flag_c);
`else
        cin = op inside {4'd1, 4'd3, 4'd15};
`endif
        ctl_d = {op inside {4'd1, 4'd3, 4'd15}, op[3:1] == 3'b111, cin, arith,
                 op == 4'd4, op == 4'd5, op == 4'd6, op == 4'd7, op == 4'd8, op == 4'd9,
                 shift ? bus.sh_amt : 4'd0, shift && op[3:1] == 3'b110, shift && !op[0],
                 shift && op[0], shift};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            ctl_q  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
            flag_n <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (bus.start) begin
                    state <= S_DRIVE;
                    ctl_q <= ctl_d;
                    busy  <= 1'b1;
                end
                S_DRIVE: begin
                    state <= SETTLE == 0 ? S_CAPTURE : S_SETTLE;
                    cnt   <= 3'(SETTLE - 1);
                end
                S_SETTLE: begin
                    cnt   <= cnt - 3'd1;
                    state <= cnt == 3'd0 ? S_CAPTURE : S_SETTLE;
                end
                S_CAPTURE: begin
                    state  <= S_DONE;
                    result <= bus.alu_out;
                    flag_n <= bus.alu_out[WIDTH-1];
                    // fa_out marks an arithmetic op: only then do the slice carry/zero chains mean anything
                    flag_z <= ctl_q[14] ? ~bus.n_z : bus.alu_out == '0;
                    flag_c <= ctl_q[14] ? bus.c_out : flag_c;
                    ctl_q  <= '0;
                    done   <= 1'b1;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
    assign {bus.sub, bus.zero_a, bus.c_in, bus.fa_out, bus.op_and, bus.op_or, bus.op_xor, bus.op_not,
            bus.op_nand, bus.op_nor, bus.sh8, bus.sh4, bus.sh2, bus.sh1, bus.sh_b, bus.sh_l, bus.sh_r,
            bus.sh_out} = ctl_q;
    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.result = result;
    assign bus.flag_z = flag_z;
    assign bus.flag_c = flag_c;
    assign bus.flag_n = flag_n;
endmodule

// File: tb/tb_alu_control.sv
// tb_alu_control: scoreboard bench for alu_control (WIDTH=16, SETTLE=1)
module tb_alu_control;
    localparam int SETTLE = 1;
`ifdef ALU_CONTROL_CARRY_IN_EN
    localparam bit CARRY_EN = 1'b1;
`else
    localparam bit CARRY_EN = 1'b0;
`endif
    typedef struct {
        logic [17:0] ctl;
        logic [15:0] res;
        logic        z;
        logic        c;
        logic        n;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [17:0] ctl;
    logic        mdl_c = 1'b0;
    int          errors = 0;
    int          checks = 0;
    exp_t        exp_q[$];
    alu_control_if #(.WIDTH(16)) bus ();
    alu_control #(.WIDTH(16), .SETTLE(SETTLE)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    assign ctl = {bus.sub, bus.zero_a, bus.c_in, bus.fa_out, bus.op_and, bus.op_or, bus.op_xor, bus.op_not,
                  bus.op_nand, bus.op_nor, bus.sh8, bus.sh4, bus.sh2, bus.sh1, bus.sh_b, bus.sh_l, bus.sh_r,
                  bus.sh_out};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [17:0] mdl_ctl(input logic [3:0] op, input logic [3:0] amt, input logic fc);
        logic s, za, ci, fa, a, o, x, n, na, no, sb, sl, sr, so;
        logic [3:0] sh;
        {s, za, ci, fa, a, o, x, n, na, no, sb, sl, sr, so} = '0;
        sh = '0;
        case (op)
            4'd0:  fa = 1'b1;
            4'd1:  begin fa = 1'b1; s = 1'b1; ci = 1'b1; end
            4'd2:  begin fa = 1'b1; ci = CARRY_EN ? fc : 1'b0; end
            4'd3:  begin fa = 1'b1; s = 1'b1; ci = CARRY_EN ? fc : 1'b1; end
            4'd4:  a = 1'b1;
            4'd5:  o = 1'b1;
            4'd6:  x = 1'b1;
            4'd7:  n = 1'b1;
            4'd8:  na = 1'b1;
            4'd9:  no = 1'b1;
            4'd10: begin so = 1'b1; sl = 1'b1; sh = amt; end
            4'd11: begin so = 1'b1; sr = 1'b1; sh = amt; end
            4'd12: begin so = 1'b1; sl = 1'b1; sb = 1'b1; sh = amt; end
            4'd13: begin so = 1'b1; sr = 1'b1; sb = 1'b1; sh = amt; end
            4'd14: begin fa = 1'b1; za = 1'b1; end
            default: begin fa = 1'b1; za = 1'b1; s = 1'b1; ci = 1'b1; end
        endcase
        return {s, za, ci, fa, a, o, x, n, na, no, sh, sb, sl, sr, so};
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [3:0] amt, input logic [15:0] alu,
                          input logic cout, input logic nz, input bit hold);
        exp_t e;
        bit   arith;
        bit   seen;
        arith = op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd14, 4'd15};
        e.ctl = mdl_ctl(op, amt, mdl_c);
        e.res = alu;
        e.n   = alu[15];
        e.z   = arith ? ~nz : (alu == 16'd0);
        e.c   = arith ? cout : mdl_c;
        exp_q.push_back(e);
        bus.start = 1'b1;
        bus.opcode = op;
        bus.sh_amt = amt;
        bus.alu_out = alu;
        bus.c_out = cout;
        bus.n_z = nz;
        step();
        bus.start = hold;
        bus.opcode = ~op;
        bus.sh_amt = ~amt;
        seen = 1'b0;
        for (int cyc = 1; cyc <= 10 && !seen; cyc++) begin
            if (bus.done) begin
                seen = 1'b1;
                e = exp_q.pop_front();
                chk("latency", cyc, 3 + SETTLE);
                chk("done_busy", bus.busy, 1);
                chk("done_ctl", ctl, 0);
                chk("result", bus.result, e.res);
                chk("flags_zcn", {bus.flag_z, bus.flag_c, bus.flag_n}, {e.z, e.c, e.n});
                mdl_c = e.c;
                bus.start = 1'b0;
            end else begin
                chk("ctl", ctl, exp_q[0].ctl);
                chk("busy", bus.busy, 1);
            end
            step();
            if (hold && !seen) bus.opcode = bus.opcode + 4'd3;
        end
        if (!seen) begin
            chk("done_timeout", 0, 1);
            void'(exp_q.pop_front());
            bus.start = 1'b0;
        end
        chk("idle_after", {bus.busy, bus.done, ctl}, 0);
        step();
        chk("idle_after2", {bus.busy, bus.done}, 0);
    endtask

    initial begin
        bus.start = 1'b1;
        bus.opcode = 4'd0;
        bus.sh_amt = 4'd0;
        bus.alu_out = 16'h0;
        bus.c_out = 1'b0;
        bus.n_z = 1'b1;
        step();
        step();
        rst = 1'b0;
        bus.start = 1'b0;
        chk("reset_state", {bus.busy, bus.done, ctl, bus.flag_z, bus.flag_c, bus.flag_n}, 0);
        chk("reset_result", bus.result, 0);
        run_op(4'd0, 4'd0, 16'h0005, 1'b0, 1'b1, 1'b0);
        run_op(4'd1, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b0);
        run_op(4'd11, 4'hA, 16'h8000, 1'b0, 1'b1, 1'b0);
        run_op(4'd2, 4'd3, 16'h1234, 1'b0, 1'b1, 1'b0);
        run_op(4'd3, 4'd0, 16'h00F0, 1'b1, 1'b1, 1'b0);
        run_op(4'd3, 4'd0, 16'h0F00, 1'b0, 1'b1, 1'b0);
        run_op(4'd0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b0);
        run_op(4'd2, 4'd0, 16'h0001, 1'b1, 1'b1, 1'b0);
        run_op(4'd12, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++)
            run_op(4'(i), 4'($urandom_range(0, 15)), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        run_op(4'd6, 4'd5, 16'hA5A5, 1'b0, 1'b1, 1'b1);
        bus.start = 1'b1;
        bus.opcode = 4'd4;
        bus.alu_out = 16'h1111;
        step();
        bus.start = 1'b0;
        step();
        chk("settle_ctl", ctl, mdl_ctl(4'd4, 4'd0, mdl_c));
        rst = 1'b1;
        bus.start = 1'b1;
        step();
        chk("midrst_state", {bus.busy, bus.done, ctl, bus.flag_z, bus.flag_c, bus.flag_n}, 0);
        chk("midrst_result", bus.result, 0);
        step();
        rst = 1'b0;
        bus.start = 1'b0;
        mdl_c = 1'b0;
        chk("start_in_rst", bus.busy, 0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("no_done_after_rst", {bus.busy, bus.done}, 0);
        end
        run_op(4'd13, 4'd1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        run_op(4'd15, 4'd0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_control.md
ALU_CONTROL -- requirements
Module: alu_control

Interface
REQ-001 Parameter: WIDTH, 16, datapath width (number of ALU slices).
REQ-002 Parameter: SETTLE, 1, extra cycles slice controls are held before result capture (range 0..7).
REQ-003 Clock  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Start  input  1  operation request; sampled only in IDLE.
REQ-006 Opcode  input  4  operation code, table in REQ-014.
REQ-007 ShAmt  input  4  shift distance 0..15 for shift opcodes.
REQ-008 Busy  output  1  high from accept until Done cycle inclusive.
REQ-009 Done  output  1  one-cycle pulse; Result/flags valid from this cycle.
REQ-010 SUB, ZeroA, CIn, FAOut, AND, OR, XOR, NOT, NAND, NOR, Sh8, Sh4, Sh2, Sh1, ShB, ShL, ShR, ShOut  output  1 each  registered slice control lines, broadcast to all slices.
REQ-011 ALUOut  input  WIDTH  slice outputs; COut  input  1  MSB carry; nZ  input  1  end of nZ chain.
REQ-012 Result  output  WIDTH  captured ALUOut; FlagZ, FlagC, FlagN  output  1 each  status flags.

Function
REQ-013 FSM states IDLE, DRIVE, SETTLE, CAPTURE, DONE; IDLE->DRIVE on Start; DRIVE->SETTLE (or CAPTURE if SETTLE=0); SETTLE->CAPTURE after SETTLE cycles; CAPTURE->DONE; DONE->IDLE.
REQ-014 Opcodes: 0 ADD, 1 SUB, 2 ADC, 3 SBC, 4 AND, 5 OR, 6 XOR, 7 NOT A, 8 NAND, 9 NOR, 10 LSL A, 11 LSR A, 12 LSL B, 13 LSR B, 14 PASS B, 15 NEG B.
REQ-015 Arithmetic: FAOut=1; SUB=1 for 1,3,15; CIn=1 for 1,15, CIn=0 for 0,14; ZeroA=1 for 14,15.
REQ-016 Logic opcodes: exactly one of AND/OR/XOR/NOT/NAND/NOR high; FAOut=ShOut=0.
REQ-017 Shifts: ShOut=1; ShL for 10,12, ShR for 11,13; ShB=1 for 12,13; Sh8/Sh4/Sh2/Sh1 = ShAmt[3:0]; ShAmt=0 gives unshifted operand.
REQ-018 Controls latched at accept, valid from DRIVE through CAPTURE, all zero in IDLE and DONE; Opcode/ShAmt changes after accept ignored.
REQ-019 CAPTURE edge: Result<=ALUOut; FlagN<=ALUOut[WIDTH-1]; FlagZ<=~nZ for arithmetic, (ALUOut==0) otherwise; FlagC<=COut for arithmetic, unchanged for logic/shift.
REQ-020 Latency: Start sampled at edge n -> Done high in cycle n+3+SETTLE; Busy high cycles n+1..n+3+SETTLE.
REQ-021 Start while Busy ignored, no queueing; next accept earliest cycle after Done.
REQ-022 Result and flags hold until next CAPTURE.

Reset
REQ-023 Reset, including mid-operation, forces IDLE next edge; all control lines, Busy, Done, Result, flags = 0; in-flight operation discarded, no Done.
REQ-024 Start asserted with Reset ignored.

Configuration
REQ-025 Macro ALU_CONTROL_CARRY_IN_EN: defined -> ADC/SBC drive CIn=FlagC; undefined -> ADC decodes as ADD (CIn=0), SBC as SUB (CIn=1).

Verification
REQ-026 Reset, then Start Opcode=0, ALUOut stub=0x0005, COut=0, nZ=1 -> Done at n+4 (SETTLE=1), Result=0x0005, Z=0 C=0 N=0.
REQ-027 Opcode=1 with COut=1, nZ=0, ALUOut=0 -> SUB=1, CIn=1, FAOut=1 during DRIVE..CAPTURE; Z=1 C=1.
REQ-028 Opcode=11, ShAmt=0xA -> ShR=1, Sh8=1, Sh2=1, Sh4=Sh1=0, ShOut=1, ShB=0; FlagC unchanged.
REQ-029 Start held high across busy window and Opcode toggled -> exactly one Done, controls match first opcode.
REQ-030 Reset in SETTLE -> next cycle all outputs 0, no Done; Opcode=3 with macro defined and FlagC=1 -> CIn=1, without macro CIn=1 regardless of FlagC.
